// File: rtl/midi_pkg.sv
// Shared MIDI constants, receiver/parser state encodings and note-range helper
// for the MIDI note decoder.
package midi_pkg;

  localparam logic [7:0] STATUS_NOTE_OFF = 8'h80;
  localparam logic [7:0] STATUS_NOTE_ON  = 8'h90;
  localparam logic [7:0] STATUS_REALTIME = 8'hF8;

  localparam logic [6:0] NOTE_MIN = 7'd21;
  localparam logic [6:0] NOTE_MAX = 7'd108;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  typedef enum logic [1:0] {P_IDLE, P_D1, P_D2} parser_state_t;

  function automatic logic note_in_range(input logic [6:0] note);
    return (note >= NOTE_MIN) && (note <= NOTE_MAX);
  endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// 8N1 serial receiver for the MIDI line: synchronizes rx, samples mid-bit and
// emits a one-cycle strobe per good byte or a frame_err pulse on a low stop bit.
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 31250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       strobe,
  output logic       frame_err
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);

  logic          sync1, sync2, rx_prev;
  rx_state_t     state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0]    bit_idx, bit_next;
  logic [7:0]    shift, shift_next;
  logic          strobe_next, ferr_next;

  // Synchronizer and edge-detect flops idle high so reset never fakes a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= rx;
      sync2   <= sync1;
      rx_prev <= sync2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      strobe    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      bit_idx   <= bit_next;
      shift     <= shift_next;
      strobe    <= strobe_next;
      frame_err <= ferr_next;
    end
  end

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    bit_next    = bit_idx;
    shift_next  = shift;
    strobe_next = 1'b0;
    ferr_next   = 1'b0;
    case (state)
      IDLE: begin
        if (rx_prev && !sync2) begin
          state_next = START;
          cnt_next   = '0;
        end
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_next   = '0;
          bit_next   = '0;
          state_next = sync2 ? IDLE : DATA;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_next   = '0;
          shift_next = {sync2, shift[7:1]};
          bit_next   = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_next = STOP;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          state_next  = IDLE;
          strobe_next = sync2;
          ferr_next   = !sync2;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign data = shift;

endmodule

// File: rtl/midi_decoder.sv
// MIDI note decoder: parses note-on/off messages (with running status) from the
// serial line and drives a monophonic, last-note-priority oscillator index.
module midi_decoder
  import midi_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int BAUD    = 31250,
  parameter int OMNI    = 1,
  parameter int CHANNEL = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       midi_rx,
  output logic [6:0] freq,
  output logic [6:0] velocity,
  output logic       note_on,
  output logic       note_valid,
  output logic       frame_err
);

  localparam logic [3:0] CHAN = 4'(CHANNEL);

  logic [7:0]    rx_data;
  logic          rx_strobe;
  parser_state_t p_state, p_next;
  logic          run_on, run_on_next;
  logic [6:0]    note, note_next;
  logic [6:0]    freq_next, vel_next, idx;
  logic          on_next, valid_next;
  logic          chan_ok, is_note_status, key_on;

  midi_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (midi_rx),
    .data      (rx_data),
    .strobe    (rx_strobe),
    .frame_err (frame_err)
  );

  assign chan_ok        = (OMNI != 0) || (rx_data[3:0] == CHAN);
  assign is_note_status = (rx_data[7:4] == STATUS_NOTE_ON[7:4]) ||
                          (rx_data[7:4] == STATUS_NOTE_OFF[7:4]);
  assign key_on         = run_on && (rx_data[6:0] != 7'd0);
  assign idx            = note - NOTE_MIN;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_state    <= P_IDLE;
      run_on     <= 1'b0;
      note       <= '0;
      freq       <= '0;
      velocity   <= '0;
      note_on    <= 1'b0;
      note_valid <= 1'b0;
    end else begin
      p_state    <= p_next;
      run_on     <= run_on_next;
      note       <= note_next;
      freq       <= freq_next;
      velocity   <= vel_next;
      note_on    <= on_next;
      note_valid <= valid_next;
    end
  end

  // Real-time bytes (0xF8..0xFF) fall through untouched so they can interleave a message.
  always_comb begin
    p_next      = p_state;
    run_on_next = run_on;
    note_next   = note;
    freq_next   = freq;
    vel_next    = velocity;
    on_next     = note_on;
    valid_next  = 1'b0;
    if (rx_strobe && (rx_data < STATUS_REALTIME)) begin
      if (rx_data[7]) begin
        if (is_note_status && chan_ok) begin
          run_on_next = (rx_data[7:4] == STATUS_NOTE_ON[7:4]);
          p_next      = P_D1;
        end else begin
          run_on_next = 1'b0;
          p_next      = P_IDLE;
        end
      end else begin
        case (p_state)
          P_D1: begin
            note_next = rx_data[6:0];
            p_next    = P_D2;
          end
          P_D2: begin
            p_next = P_D1;
            if (note_in_range(note)) begin
              if (key_on) begin
                freq_next  = idx;
                vel_next   = rx_data[6:0];
                on_next    = 1'b1;
                valid_next = 1'b1;
              end else if (note_on && (idx == freq)) begin
                on_next    = 1'b0;
                valid_next = 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_midi_decoder.sv
// Directed testbench for midi_decoder: serializes MIDI bytes onto the line of an
// OMNI instance and a channel-2 instance and checks the decoded note outputs.
module tb_midi_decoder;

  localparam int DIV = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx0 = 1'b1;
  logic       rx1 = 1'b1;
  logic [6:0] freq0, vel0, freq1, vel1;
  logic       on0, valid0, ferr0, on1, valid1, ferr1;

  int checks = 0;
  int failures = 0;
  int valid_cnt0 = 0;
  int valid_cnt1 = 0;
  int ferr_cnt0 = 0;

  always #5 clk = ~clk;

  midi_decoder #(.CLK_HZ(500_000), .BAUD(31250), .OMNI(1), .CHANNEL(0)) dut0 (
    .clk(clk), .reset(reset), .midi_rx(rx0), .freq(freq0), .velocity(vel0),
    .note_on(on0), .note_valid(valid0), .frame_err(ferr0)
  );

  midi_decoder #(.CLK_HZ(500_000), .BAUD(31250), .OMNI(0), .CHANNEL(2)) dut1 (
    .clk(clk), .reset(reset), .midi_rx(rx1), .freq(freq1), .velocity(vel1),
    .note_on(on1), .note_valid(valid1), .frame_err(ferr1)
  );

  always @(negedge clk) begin
    if (valid0) valid_cnt0++;
    if (valid1) valid_cnt1++;
    if (ferr0)  ferr_cnt0++;
  end

  task automatic set_line(input int which, input logic v);
    if (which == 0) rx0 = v;
    else rx1 = v;
  endtask

  task automatic bit_time();
    repeat (DIV) @(posedge clk);
  endtask

  task automatic send_frame(input int which, input logic [7:0] b, input logic stop);
    set_line(which, 1'b0);
    bit_time();
    for (int i = 0; i < 8; i++) begin
      set_line(which, b[i]);
      bit_time();
    end
    set_line(which, stop);
    bit_time();
    set_line(which, 1'b1);
    repeat (2 * DIV) @(posedge clk);
  endtask

  task automatic send_byte(input int which, input logic [7:0] b);
    send_frame(which, b, 1'b1);
  endtask

  task automatic test_reset();
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++; if (freq0 !== 7'd0) begin failures++; $display("[TB] FAIL reset_freq: got %0d expected 0", freq0); end
    checks++; if (vel0 !== 7'd0) begin failures++; $display("[TB] FAIL reset_vel: got %0d expected 0", vel0); end
    checks++; if (on0 !== 1'b0) begin failures++; $display("[TB] FAIL reset_on: got %b expected 0", on0); end
    checks++; if (valid0 !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", valid0); end
    checks++; if (ferr0 !== 1'b0) begin failures++; $display("[TB] FAIL reset_ferr: got %b expected 0", ferr0); end
    checks++; if (freq1 !== 7'd0) begin failures++; $display("[TB] FAIL reset_freq1: got %0d expected 0", freq1); end
    checks++; if (on1 !== 1'b0) begin failures++; $display("[TB] FAIL reset_on1: got %b expected 0", on1); end
    checks++; if (ferr1 !== 1'b0) begin failures++; $display("[TB] FAIL reset_ferr1: got %b expected 0", ferr1); end
    reset = 1'b0;
    repeat (2 * DIV) @(posedge clk);
  endtask

  task automatic test_note_on();
    int v = valid_cnt0;
    send_byte(0, 8'h90); send_byte(0, 8'h45); send_byte(0, 8'h64);
    @(negedge clk);
    checks++; if (valid_cnt0 - v !== 1) begin failures++; $display("[TB] FAIL on_valid_count: got %0d expected 1", valid_cnt0 - v); end
    checks++; if (freq0 !== 7'd48) begin failures++; $display("[TB] FAIL on_freq: got %0d expected 48", freq0); end
    checks++; if (vel0 !== 7'd100) begin failures++; $display("[TB] FAIL on_vel: got %0d expected 100", vel0); end
    checks++; if (on0 !== 1'b1) begin failures++; $display("[TB] FAIL on_level: got %b expected 1", on0); end
  endtask

  task automatic test_running_status();
    int v = valid_cnt0;
    send_byte(0, 8'h3C); send_byte(0, 8'h40);
    @(negedge clk);
    checks++; if (valid_cnt0 - v !== 1) begin failures++; $display("[TB] FAIL run_valid_count: got %0d expected 1", valid_cnt0 - v); end
    checks++; if (freq0 !== 7'd39) begin failures++; $display("[TB] FAIL run_freq: got %0d expected 39", freq0); end
    checks++; if (vel0 !== 7'd64) begin failures++; $display("[TB] FAIL run_vel: got %0d expected 64", vel0); end
    checks++; if (on0 !== 1'b1) begin failures++; $display("[TB] FAIL run_on: got %b expected 1", on0); end
    v = valid_cnt0;
    send_byte(0, 8'h80); send_byte(0, 8'h45); send_byte(0, 8'h00);
    @(negedge clk);
    checks++; if (on0 !== 1'b1) begin failures++; $display("[TB] FAIL off_other_on: got %b expected 1", on0); end
    checks++; if (valid_cnt0 - v !== 0) begin failures++; $display("[TB] FAIL off_other_valid: got %0d expected 0", valid_cnt0 - v); end
  endtask

  task automatic test_realtime();
    int v = valid_cnt0;
    send_byte(0, 8'h90); send_byte(0, 8'h3C); send_byte(0, 8'hF8); send_byte(0, 8'h00);
    @(negedge clk);
    checks++; if (on0 !== 1'b0) begin failures++; $display("[TB] FAIL rt_on: got %b expected 0", on0); end
    checks++; if (freq0 !== 7'd39) begin failures++; $display("[TB] FAIL rt_freq: got %0d expected 39", freq0); end
    checks++; if (vel0 !== 7'd64) begin failures++; $display("[TB] FAIL rt_vel: got %0d expected 64", vel0); end
    checks++; if (valid_cnt0 - v !== 1) begin failures++; $display("[TB] FAIL rt_valid_count: got %0d expected 1", valid_cnt0 - v); end
  endtask

  task automatic test_frame_err();
    int v = valid_cnt0;
    int f = ferr_cnt0;
    send_frame(0, 8'h15, 1'b0);
    @(negedge clk);
    checks++; if (ferr_cnt0 - f !== 1) begin failures++; $display("[TB] FAIL ferr_count: got %0d expected 1", ferr_cnt0 - f); end
    checks++; if (freq0 !== 7'd39) begin failures++; $display("[TB] FAIL ferr_freq: got %0d expected 39", freq0); end
    checks++; if (on0 !== 1'b0) begin failures++; $display("[TB] FAIL ferr_on: got %b expected 0", on0); end
    send_byte(0, 8'h50);
    @(negedge clk);
    checks++; if (valid_cnt0 - v !== 0) begin failures++; $display("[TB] FAIL ferr_discard_valid: got %0d expected 0", valid_cnt0 - v); end
    send_byte(0, 8'h90); send_byte(0, 8'h10); send_byte(0, 8'h50);
    @(negedge clk);
    checks++; if (valid_cnt0 - v !== 0) begin failures++; $display("[TB] FAIL low_range_valid: got %0d expected 0", valid_cnt0 - v); end
    checks++; if (freq0 !== 7'd39) begin failures++; $display("[TB] FAIL low_range_freq: got %0d expected 39", freq0); end
  endtask

  task automatic test_boundaries();
    int v = valid_cnt0;
    send_byte(0, 8'h90); send_byte(0, 8'h15); send_byte(0, 8'h01);
    @(negedge clk);
    checks++; if (freq0 !== 7'd0) begin failures++; $display("[TB] FAIL min_freq: got %0d expected 0", freq0); end
    checks++; if (vel0 !== 7'd1) begin failures++; $display("[TB] FAIL min_vel: got %0d expected 1", vel0); end
    checks++; if (valid_cnt0 - v !== 1) begin failures++; $display("[TB] FAIL min_valid_count: got %0d expected 1", valid_cnt0 - v); end
    send_byte(0, 8'h6C); send_byte(0, 8'h7F);
    @(negedge clk);
    checks++; if (freq0 !== 7'd87) begin failures++; $display("[TB] FAIL max_freq: got %0d expected 87", freq0); end
    checks++; if (vel0 !== 7'd127) begin failures++; $display("[TB] FAIL max_vel: got %0d expected 127", vel0); end
    v = valid_cnt0;
    send_byte(0, 8'h6D); send_byte(0, 8'h20);
    @(negedge clk);
    checks++; if (freq0 !== 7'd87) begin failures++; $display("[TB] FAIL above_max_freq: got %0d expected 87", freq0); end
    checks++; if (valid_cnt0 - v !== 0) begin failures++; $display("[TB] FAIL above_max_valid: got %0d expected 0", valid_cnt0 - v); end
    send_byte(0, 8'hA0); send_byte(0, 8'h45); send_byte(0, 8'h64);
    @(negedge clk);
    checks++; if (valid_cnt0 - v !== 0) begin failures++; $display("[TB] FAIL pidle_valid: got %0d expected 0", valid_cnt0 - v); end
    checks++; if (freq0 !== 7'd87) begin failures++; $display("[TB] FAIL pidle_freq: got %0d expected 87", freq0); end
  endtask

  task automatic test_channel();
    int v = valid_cnt1;
    send_byte(1, 8'h91); send_byte(1, 8'h45); send_byte(1, 8'h64);
    @(negedge clk);
    checks++; if (valid_cnt1 - v !== 0) begin failures++; $display("[TB] FAIL chan1_valid: got %0d expected 0", valid_cnt1 - v); end
    checks++; if (on1 !== 1'b0) begin failures++; $display("[TB] FAIL chan1_on: got %b expected 0", on1); end
    send_byte(1, 8'h92); send_byte(1, 8'h45); send_byte(1, 8'h64);
    @(negedge clk);
    checks++; if (freq1 !== 7'd48) begin failures++; $display("[TB] FAIL chan2_freq: got %0d expected 48", freq1); end
    checks++; if (on1 !== 1'b1) begin failures++; $display("[TB] FAIL chan2_on: got %b expected 1", on1); end
    checks++; if (valid_cnt1 - v !== 1) begin failures++; $display("[TB] FAIL chan2_valid: got %0d expected 1", valid_cnt1 - v); end
  endtask

  task automatic test_reset_mid_byte();
    int v;
    send_byte(0, 8'h90);
    set_line(0, 1'b0); bit_time();
    set_line(0, 1'b1); bit_time();
    set_line(0, 1'b0); bit_time();
    set_line(0, 1'b1);
    repeat (DIV / 2) @(posedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (freq0 !== 7'd0) begin failures++; $display("[TB] FAIL midrst_freq: got %0d expected 0", freq0); end
    checks++; if (vel0 !== 7'd0) begin failures++; $display("[TB] FAIL midrst_vel: got %0d expected 0", vel0); end
    checks++; if (on0 !== 1'b0) begin failures++; $display("[TB] FAIL midrst_on: got %b expected 0", on0); end
    reset = 1'b0;
    repeat (2 * DIV) @(posedge clk);
    v = valid_cnt0;
    send_byte(0, 8'h90); send_byte(0, 8'h45); send_byte(0, 8'h64);
    @(negedge clk);
    checks++; if (freq0 !== 7'd48) begin failures++; $display("[TB] FAIL post_rst_freq: got %0d expected 48", freq0); end
    checks++; if (vel0 !== 7'd100) begin failures++; $display("[TB] FAIL post_rst_vel: got %0d expected 100", vel0); end
    checks++; if (on0 !== 1'b1) begin failures++; $display("[TB] FAIL post_rst_on: got %b expected 1", on0); end
    checks++; if (valid_cnt0 - v !== 1) begin failures++; $display("[TB] FAIL post_rst_valid: got %0d expected 1", valid_cnt0 - v); end
  endtask

  initial begin
    test_reset();
    test_note_on();
    test_running_status();
    test_realtime();
    test_frame_err();
    test_boundaries();
    test_channel();
    test_reset_mid_byte();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
